fifo_uart_tx: RTL
=================

Name: fifo_uart_tx

Overview:
Drain side of the byte fifo. Pops one entry at a time from a fifo instance and serialises it as an 8N1-style UART frame on a single tx pin. The fifo output is combinational: data valid while not empty. Its read side advances on a rising edge of read_en. This block generates those single-cycle pop pulses and paces them to the line rate. Sits between the fifo and the board UART pin on the Tang Nano 20K.

Parameters:
DATA_WIDTH, 8, bits per frame; must match the fifo DATA_WIDTH
CLK_FREQ, 27000000, clock frequency in Hz
BAUD, 115200, line rate in bit/s
STOP_BITS, 1, number of stop bits (1 or 2)
CLKS_PER_BIT, derived as CLK_FREQ/BAUD (integer divide), must be >= 4; localparam, not overridable

Ports:
clock  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous, active-low reset
enable  input  1  level; 1 permits starting new frames
fifo_empty  input  1  fifo empty flag
fifo_data  input  DATA_WIDTH  fifo data_out, valid while fifo_empty=0
fifo_read_en  output  1  pop request to fifo read_en, registered, one-cycle pulse per frame
tx  output  1  serial line, idle high, registered
busy  output  1  1 whenever state != IDLE
tx_done  output  1  one-cycle pulse on the last clock of the final stop bit

Behaviour:
- Reset (reset_n=0, async): tx=1, fifo_read_en=0, busy=0, tx_done=0, state=IDLE, counters=0, shift register=0. Takes effect immediately, including mid-frame. A partially sent byte is lost because it was already popped.
- States: IDLE, START, DATA, STOP.
- IDLE, when enable=1 && fifo_empty=0 on a clock edge:
  - latch fifo_data into the shift register
  - drive fifo_read_en=1 for exactly that next cycle
  - go to START with tx=0 from the next cycle
  - latency from the popping edge to the start bit on tx is 1 clock
- IDLE otherwise: tx=1, fifo_read_en=0.
- START: tx=0 for CLKS_PER_BIT cycles, then DATA.
- DATA: LSB first, each bit held for CLKS_PER_BIT cycles. Bit index runs 0..DATA_WIDTH-1, $clog2(DATA_WIDTH) bits wide. After the last bit, go to STOP.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. tx_done=1 on the final cycle, then IDLE.
- Back-to-back frames: the IDLE decision takes one cycle, so the inter-frame gap is stop time + 1 clock.
- Pop pulse spacing is always >= one frame. This guarantees the low cycle the fifo edge detector needs.
- The one-cycle-stale fifo_empty after a pop is never sampled, because the pop is followed by >= CLKS_PER_BIT cycles of START.
- Baud counter: $clog2(CLKS_PER_BIT) bits. It reloads to 0 on every state/bit transition. No drift accumulates within a frame.
- enable falling mid-frame: the current frame completes normally and no new pop is issued. enable is sampled only in IDLE.
- fifo_data changing during a frame has no effect; the frame uses the latched copy.
- fifo_empty=1 in IDLE: remain idle indefinitely, tx=1.

Decomposition:
- Shared package fifo_uart_pkg holds:
  - the state encoding (2-bit enum IDLE/START/DATA/STOP)
  - a constant function computing CLKS_PER_BIT from CLK_FREQ and BAUD
  - an elaboration check CLKS_PER_BIT >= 4
- One sub-module, baud_tick_gen, is natural: a restartable counter with inputs clock, reset_n, restart and output tick, asserting tick on count CLKS_PER_BIT-1. The FSM and shifter stay in fifo_uart_tx.

Test Plan:
All scenarios use CLK_FREQ=1000000, BAUD=100000, so CLKS_PER_BIT=10. Scenarios 3 and 5 drive a real fifo instance.
1. Reset: hold reset_n=0 with random inputs -> tx=1, fifo_read_en=0, busy=0, tx_done=0. Assert reset_n=0 asynchronously mid-DATA -> tx=1 before the next clock edge.
2. Single byte: fifo_data=0xA5, fifo_empty=0, enable=1 for one pop, then fifo_empty=1 ->
   - exactly one fifo_read_en pulse
   - tx low 10 cycles, then bits 1,0,1,0,0,1,0,1 at 10 cycles each, then high 10
   - tx_done at cycle 99 after the start bit begins
   - busy high for 100 cycles
3. Back-to-back through fifo: write 0x55, 0x0F, enable=1 ->
   - exactly 2 pops
   - frames decode as 0x55 then 0x0F
   - falling edges of the two start bits are 101 cycles apart
   - no pop after fifo empty=1
4. enable dropped at bit 3 of the first of two queued bytes -> first frame completes, tx_done pulses, no second pop while enable=0. Re-raise enable -> second frame starts 1 cycle later.
5. Reset mid-DATA with 3 bytes queued -> tx high immediately. After release, the remaining 2 bytes are sent intact with no spurious pop.
6. STOP_BITS=2, byte 0xFF -> stop high 20 cycles. fifo_data toggled every cycle during the frame -> serial output still 0xFF.

Source files
------------

// File: rtl/fifo_uart_pkg.sv
// Shared types and helpers for the fifo-draining UART transmitter.
package fifo_uart_pkg;

  // Line state of the transmitter; busy is simply "not IDLE".
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // Below this, the baud counter has too few steps to hold a bit cleanly.
  localparam int MIN_CLKS_PER_BIT = 4;

  // Clocks per serial bit; the fractional part is dropped (integer divide).
  function automatic int calc_clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Restartable bit-period counter: tick marks the last clock of each bit period.
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic clock,
  input  logic reset_n,
  input  logic restart,
  output logic tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count;

  // Count 0..CLKS_PER_BIT-1 and wrap; restart pins the count at 0.
  // NOTE: sequential state is updated with non-blocking (<=) assignments only,
  // so every register samples the values from before the clock edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (restart || (count == LAST)) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from a show-ahead fifo and sends each as an 8N1-style UART frame.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_FREQ   = 27000000,
  parameter int BAUD       = 115200,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_read_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD);
  localparam int BIT_W        = $clog2(DATA_WIDTH);
  localparam int STOP_W       = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
  localparam logic [STOP_W-1:0] STOP_LAST = STOP_W'(STOP_BITS - 1);

  if (CLKS_PER_BIT < MIN_CLKS_PER_BIT) begin : g_bad_clks_per_bit
    $error("fifo_uart_tx: CLK_FREQ/BAUD must be at least 4");
  end
  if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_stop_bits
    $error("fifo_uart_tx: STOP_BITS must be 1 or 2");
  end

  tx_state_t             state, state_next;
  logic [BIT_W-1:0]      bit_idx, bit_next;
  logic [STOP_W-1:0]     stop_idx, stop_next;
  logic [DATA_WIDTH-1:0] shreg, shreg_next;
  logic                  tx_next;
  logic                  read_next;
  logic                  tick;

  // The counter is held at 0 while idle, so the start bit gets a full period.
  // Every later bit boundary coincides with the counter wrapping to 0, so the
  // count is re-aligned at each transition and never drifts within a frame.
  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clock  (clock),
    .reset_n(reset_n),
    .restart(state == IDLE),
    .tick   (tick)
  );

  // Next-state, shifter and line-level decisions for the frame sequence.
  // NOTE: every signal assigned here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    bit_next   = bit_idx;
    stop_next  = stop_idx;
    shreg_next = shreg;
    tx_next    = tx;
    read_next  = 1'b0;
    tx_done    = 1'b0;
    unique case (state)
      IDLE: begin
        tx_next = 1'b1;
        if (enable && !fifo_empty) begin
          // Latch the byte and pop in the same edge; the frame never looks
          // at fifo_data again.
          shreg_next = fifo_data;
          read_next  = 1'b1;
          tx_next    = 1'b0;
          state_next = START;
        end
      end
      START: begin
        if (tick) begin
          state_next = DATA;
          bit_next   = '0;
          tx_next    = shreg[0];
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_idx == BIT_LAST) begin
            state_next = STOP;
            stop_next  = '0;
            tx_next    = 1'b1;
          end else begin
            bit_next   = bit_idx + 1'b1;
            shreg_next = shreg >> 1;
            tx_next    = shreg[1];
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (stop_idx == STOP_LAST) begin
            state_next = IDLE;
            tx_done    = 1'b1;
          end else begin
            stop_next = stop_idx + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, shifter, line and pop registers.
  // NOTE: the shift register is reset along with the control state; it is a
  // single register, not a memory array, so a reset costs nothing and keeps
  // its contents deterministic.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      bit_idx      <= '0;
      stop_idx     <= '0;
      shreg        <= '0;
      tx           <= 1'b1;
      fifo_read_en <= 1'b0;
    end else begin
      state        <= state_next;
      bit_idx      <= bit_next;
      stop_idx     <= stop_next;
      shreg        <= shreg_next;
      tx           <= tx_next;
      fifo_read_en <= read_next;
    end
  end

  assign busy = (state != IDLE);

endmodule
